reg_file_hybrid: RTL

//  Parametrised 3-read / 2-write register file for the hybrid ARM/MIPS core, shared by both decode paths.

---
 rtl/reg_file_hybrid.sv | 119 +++++++++++
 1 files changed

// File: rtl/reg_file_hybrid.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_hybrid
// Description : 3-read / 2-write register file shared by the ARM and MIPS
//               decode paths. Mode-dependent address mapping and special
//               registers (ARM PC read-back, MIPS hardwired zero).
//               Write-first bypass on both write ports. Per-register busy
//               scoreboard drives a combinational decode stall.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_hybrid #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int PC_IDX = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode_i,
  input  logic [AW-1:0] ra1_i,
  input  logic [AW-1:0] ra2_i,
  input  logic [AW-1:0] ra3_i,
  input  logic          ren1_i,
  input  logic          ren2_i,
  input  logic          ren3_i,
  output logic [DW-1:0] rd1_o,
  output logic [DW-1:0] rd2_o,
  output logic [DW-1:0] rd3_o,
  input  logic          we3_i,
  input  logic [AW-1:0] wa3_i,
  input  logic [DW-1:0] wd3_i,
  input  logic          we4_i,
  input  logic [AW-1:0] wa4_i,
  input  logic [DW-1:0] wd4_i,
  input  logic [DW-1:0] pc_in_i,
  input  logic          rsv_en_i,
  input  logic [AW-1:0] rsv_addr_i,
  output logic          stall_o
);

  localparam int            NREGS    = 2**AW;
  localparam logic [AW-1:0] c_PC_IDX = AW'(PC_IDX);
  localparam logic [AW-1:0] c_ZERO   = '0;

  // ARM only sees the low four address bits; MIPS uses the full address.
  function automatic logic [AW-1:0] map_addr(input logic m, input logic [AW-1:0] a);
    return m ? a : {{(AW-4){1'b0}}, a[3:0]};
  endfunction

  // Special registers never store data and never hold a reservation.
  function automatic logic is_special(input logic m, input logic [AW-1:0] ma);
    return m ? (ma == c_ZERO) : (ma == c_PC_IDX);
  endfunction

  logic [DW-1:0]    rf_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic [AW-1:0] w_m1, w_m2, w_m3;
  logic [AW-1:0] w_mw3, w_mw4, w_mrsv;
  logic          w_wr3, w_wr4, w_rsv;

  assign w_m1   = map_addr(mode_i, ra1_i);
  assign w_m2   = map_addr(mode_i, ra2_i);
  assign w_m3   = map_addr(mode_i, ra3_i);
  assign w_mw3  = map_addr(mode_i, wa3_i);
  assign w_mw4  = map_addr(mode_i, wa4_i);
  assign w_mrsv = map_addr(mode_i, rsv_addr_i);
  assign w_wr3  = we3_i && !is_special(mode_i, w_mw3);
  assign w_wr4  = we4_i && !is_special(mode_i, w_mw4);
  assign w_rsv  = rsv_en_i && !is_special(mode_i, w_mrsv);

  // Read data: special register, then port-3 bypass, then port-4 bypass, then array.
  function automatic logic [DW-1:0] read_port(input logic [AW-1:0] ma);
    if (is_special(mode_i, ma)) return mode_i ? '0 : pc_in_i;
    if (we3_i && (w_mw3 == ma)) return wd3_i;
    if (we4_i && (w_mw4 == ma)) return wd4_i;
    return rf_q[ma];
  endfunction

  // A register being written back on port 3 this cycle is no longer busy.
  function automatic logic port_busy(input logic [AW-1:0] ma);
    return busy_q[ma] && !(we3_i && (w_mw3 == ma)) && !is_special(mode_i, ma);
  endfunction

  // Combinational read ports and decode stall.
  always_comb begin
    rd1_o   = read_port(w_m1);
    rd2_o   = read_port(w_m2);
    rd3_o   = read_port(w_m3);
    stall_o = (ren1_i && port_busy(w_m1)) ||
              (ren2_i && port_busy(w_m2)) ||
              (ren3_i && port_busy(w_m3));
  end

  // Scoreboard next state: port-3 writeback releases, reservation sets (set wins).
  always_comb begin
    busy_d = busy_q;
    if (we3_i) busy_d[w_mw3] = 1'b0;
    if (w_rsv) busy_d[w_mrsv] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Register array writes; port 3 is issued last so it wins a same-register collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      if (w_wr4) rf_q[w_mw4] <= wd4_i;
      if (w_wr3) rf_q[w_mw3] <= wd3_i;
    end
  end

endmodule
`default_nettype wire
